// File: rtl/xorshift32_rewind.sv
// xorshift32_rewind
//
// Backward stepper for the XorShift32 generator (a=13 left, b=17 right,
// c=5 left). Given a generator state and a step count it returns the state
// that many forward steps earlier. Each inverse step takes three cycles,
// undoing the forward xorshifts in reverse order: c, then b, then a.
//
// Optional feature macro: XORSHIFT32_REWIND_CHECK_EN
//   When defined, every inverse step is re-run forward and compared with the
//   value the step started from. Any disagreement sets the sticky chk_err.
//   When undefined, chk_err is tied low.
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   start       request pulse, accepted only in IDLE
//   state_in    generator state to rewind from
//   steps       number of inverse steps (0 is legal)
//   busy        high in every state except IDLE
//   done        one-cycle pulse when state_out holds the result
//   state_out   working/result register; held until the next accepted start
//   steps_left  inverse steps still to apply
//   chk_err     sticky self-check mismatch flag

module xorshift32_rewind #(
  parameter int STEP_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [31:0]       state_in,
  input  logic [STEP_W-1:0] steps,
  output logic              busy,
  output logic              done,
  output logic [31:0]       state_out,
  output logic [STEP_W-1:0] steps_left,
  output logic              chk_err
);

  typedef enum logic [2:0] {
    IDLE,
    UNDO_C,
    UNDO_B,
    UNDO_A,
    DONE
  } state_t;

  state_t state, state_next;

  logic [31:0] undo_c_val;
  logic [31:0] undo_b_val;
  logic [31:0] undo_a_val;
  logic        accept;

  // Inverse of x ^= x << 5: accumulate every multiple of 5 that fits in 32 bits.
  assign undo_c_val = state_out ^ (state_out << 5) ^ (state_out << 10) ^
                      (state_out << 15) ^ (state_out << 20) ^
                      (state_out << 25) ^ (state_out << 30);
  // Inverse of x ^= x >> 17: the second term (>> 34) is already zero.
  assign undo_b_val = state_out ^ (state_out >> 17);
  // Inverse of x ^= x << 13.
  assign undo_a_val = state_out ^ (state_out << 13) ^ (state_out << 26);

  assign accept = (state == IDLE) && start;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = (steps == '0) ? DONE : UNDO_C;
        end
      end
      UNDO_C: state_next = UNDO_B;
      UNDO_B: state_next = UNDO_A;
      // steps_left is decremented this cycle, so 1 here means the last step.
      UNDO_A: state_next = (steps_left == STEP_W'(1)) ? DONE : UNDO_C;
      DONE:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_out  <= '0;
      steps_left <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state_out  <= state_in;
            steps_left <= steps;
          end
        end
        UNDO_C: state_out <= undo_c_val;
        UNDO_B: state_out <= undo_b_val;
        UNDO_A: begin
          state_out  <= undo_a_val;
          steps_left <= steps_left - STEP_W'(1);
        end
        default: ;
      endcase
    end
  end

`ifdef XORSHIFT32_REWIND_CHECK_EN
  logic [31:0] s_prev;
  logic [31:0] fwd_1;
  logic [31:0] fwd_2;
  logic [31:0] fwd_3;

  // Forward step applied to the freshly rewound value.
  assign fwd_1 = undo_a_val ^ (undo_a_val << 13);
  assign fwd_2 = fwd_1 ^ (fwd_1 >> 17);
  assign fwd_3 = fwd_2 ^ (fwd_2 << 5);

  // s_prev always holds the value the current step started from; the result
  // of UNDO_A becomes the starting value of the following step.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_prev  <= '0;
      chk_err <= 1'b0;
    end else if (accept) begin
      s_prev  <= state_in;
      chk_err <= 1'b0;
    end else if (state == UNDO_A) begin
      s_prev <= undo_a_val;
      if (fwd_3 != s_prev) begin
        chk_err <= 1'b1;
      end
    end
  end
`else
  assign chk_err = 1'b0;
`endif

endmodule
